tank_controller: RTL and testbench
==================================

# tank_controller

Per-player tank state engine feeding the colour mapper. Once per video frame it updates the tank's position and facing from keyboard keycodes and runs a single-bullet fire/flight/cooldown state machine. Every Clk it also decodes whether the current pixel (DrawX, DrawY) lies on the tank or on the bullet. One instance per player; outputs go straight to the colour mapper's is_tank*/tank_dir*/tankX*/tankY*/is_shooting* inputs.

## Interface
- KEY_UP, 8'h1A, keycode for up (player 1 W; player 2 instance overrides)
- KEY_DOWN, 8'h16, keycode for down
- KEY_LEFT, 8'h04, keycode for left
- KEY_RIGHT, 8'h07, keycode for right
- KEY_FIRE, 8'h2C, keycode for fire
- START_X, 10'd32, reset tank X (top-left)
- START_Y, 10'd224, reset tank Y
- START_DIR, 3'b010, reset facing
- TANK_STEP, 10'd2, pixels per frame for tank
- BULLET_STEP, 10'd6, pixels per frame for bullet
- COOLDOWN_FRAMES, 6'd30, frames after bullet ends before re-fire
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  VGA vsync-derived frame tick (Clk domain)
- keycode_a, keycode_b  in  8 each  two keyboard slots, 8'h00 = none
- DrawX, DrawY  in  10 each  current pixel
- tankX, tankY  out  10 each  tank top-left
- tank_dir  out  3  001 up, 010 right, 011 left, 100 down
- is_tank  out  1  pixel inside tank
- bulletX, bulletY  out  10 each  bullet top-left
- is_shooting  out  1  bullet in flight
- is_bullet  out  1  pixel inside bullet

## Operation
- Tank 32x32, bullet 4x4, field 640x480. Tank range X 0..608, Y 0..448.
- frame_q registers frame_clk; frame_pulse = frame_clk & ~frame_q. All state below updates only on Clk edges where frame_pulse = 1.
- Movement key: first of keycode_a, keycode_b that matches a direction key; a wins over b. No match means no move and facing is kept.
- On a movement key, tank_dir takes the key's direction even if movement is blocked. Position moves by TANK_STEP, clamped to the range (up: tankY < TANK_STEP gives 0; right: min(tankX+STEP, 608); and so on). Arithmetic uses 11 bits, no wrap.
- Fire request: either slot equals KEY_FIRE.
- Bullet FSM:
  - IDLE: on fire request go to FLIGHT. Bullet spawns at (tankX+14, tankY+14) and latches bullet direction = tank_dir. Both values are pre-update, same-frame.
  - FLIGHT: each frame advance BULLET_STEP in the latched direction. If the next position would be <0, >636 (X) or >476 (Y), go to COOLDOWN with cnt = COOLDOWN_FRAMES-1; the position is not updated.
  - COOLDOWN: decrement cnt each frame. At cnt = 0 go to IDLE.
- Fire in FLIGHT or COOLDOWN is ignored. is_shooting = (state == FLIGHT).
- Fire needs re-arming. A shot is taken only if fire was absent in some frame since the previous shot (fire_armed flag, set by any frame without a fire request, cleared on a shot). Overridden by macro, see Configuration.
- is_tank = tankX ≤ DrawX < tankX+32 and tankY ≤ DrawY < tankY+32, combinational.
- is_bullet = FLIGHT and same test with size 4, combinational.

## Timing
- Reset (async, Reset_n low):
  - tankX = START_X, tankY = START_Y, tank_dir = START_DIR
  - bulletX = bulletY = 0, FSM = IDLE, cnt = 0, fire_armed = 1
  - frame_q = 1, which blocks a spurious pulse if frame_clk is high at release
  - is_shooting = 0, is_bullet = 0; is_tank follows DrawX/DrawY
- Registered outputs change on the first Clk edge at which frame_clk is high after being low. Latency is 1 Clk from frame_clk rising.
- One update per frame_clk high period, regardless of its length.
- Reset asserted mid-flight aborts the bullet immediately. After release: no bullet until a fire request on a subsequent frame.
- is_tank/is_bullet have zero-cycle latency from DrawX/DrawY and reflect the current registered positions.

## Configuration
- TANK_AUTOFIRE_EN defined: fire_armed logic removed. A held fire key re-fires on the first frame the FSM is IDLE.
- TANK_AUTOFIRE_EN undefined (default): the fire key must be released for at least one frame between shots.

## Test plan
- Reset with START_X=32, START_Y=224: outputs are 32/224/010, is_shooting=0. Then 1 frame of keycode_a=8'h07: tankX=34, tank_dir=010.
- Tank at tankY=1, hold up for 2 frames: tankY=0 after frame 1 and stays 0; tank_dir=001.
- keycode_a=8'h04, keycode_b=8'h07 for 1 frame from X=32: tankX=30, tank_dir=011.
- Tank (100,100) facing right, fire 1 frame: bullet (114,114), is_shooting=1. After it reaches X≥632 and the next step exceeds 636: is_shooting=0. Exactly 30 frames later FSM is IDLE and fire works again.
- Fire held continuously through cooldown: no second shot without the macro; with TANK_AUTOFIRE_EN a second shot fires on the frame IDLE is reached.
- Reset_n pulsed low mid-flight between Clk edges: is_shooting drops asynchronously and positions return to START values.

Source files
------------

// File: rtl/tank_controller.sv
// ============================================================================
// tank_controller
// ----------------------------------------------------------------------------
// Per-player tank state engine for the colour mapper.
//
// Once per video frame (rising edge of frame_clk, seen in the Clk domain)
// the block moves the tank from the keyboard keycodes and steps a
// single-bullet IDLE -> FLIGHT -> COOLDOWN state machine. Every Clk it
// decodes combinationally whether the current pixel (DrawX, DrawY) lies on
// the 32x32 tank or on the 4x4 bullet.
//
// Ports
//   Clk          in   1   system clock
//   Reset_n      in   1   asynchronous, active-low reset
//   frame_clk    in   1   frame tick (vsync derived, Clk domain)
//   keycode_a    in   8   keyboard slot A (8'h00 = none), wins over B
//   keycode_b    in   8   keyboard slot B (8'h00 = none)
//   DrawX/DrawY  in  10   current pixel
//   tankX/tankY  out 10   tank top-left
//   tank_dir     out  3   001 up, 010 right, 011 left, 100 down
//   is_tank      out  1   pixel inside tank
//   bulletX/Y    out 10   bullet top-left
//   is_shooting  out  1   bullet in flight
//   is_bullet    out  1   pixel inside bullet (only while in flight)
//
// Build option
//   TANK_AUTOFIRE_EN  defined: a held fire key re-fires on the first frame
//                     the bullet FSM is IDLE.
//                     undefined (default): the fire key must be released
//                     for at least one frame between shots.
// ============================================================================
`timescale 1ns/1ps

module tank_controller #(
    parameter logic [7:0] KEY_UP          = 8'h1A,
    parameter logic [7:0] KEY_DOWN        = 8'h16,
    parameter logic [7:0] KEY_LEFT        = 8'h04,
    parameter logic [7:0] KEY_RIGHT       = 8'h07,
    parameter logic [7:0] KEY_FIRE        = 8'h2C,
    parameter logic [9:0] START_X         = 10'd32,
    parameter logic [9:0] START_Y         = 10'd224,
    parameter logic [2:0] START_DIR       = 3'b010,
    parameter logic [9:0] TANK_STEP       = 10'd2,
    parameter logic [9:0] BULLET_STEP     = 10'd6,
    parameter logic [5:0] COOLDOWN_FRAMES = 6'd30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode_a,
    input  logic [7:0] keycode_b,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] tankX,
    output logic [9:0] tankY,
    output logic [2:0] tank_dir,
    output logic       is_tank,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       is_shooting,
    output logic       is_bullet
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0]  DIR_NONE     = 3'b000;
    localparam logic [2:0]  DIR_UP       = 3'b001;
    localparam logic [2:0]  DIR_RIGHT    = 3'b010;
    localparam logic [2:0]  DIR_LEFT     = 3'b011;
    localparam logic [2:0]  DIR_DOWN     = 3'b100;

    localparam logic [10:0] TANK_SIZE    = 11'd32;
    localparam logic [10:0] BULLET_SIZE  = 11'd4;
    localparam logic [10:0] TANK_X_MAX   = 11'd608;   // 640 - 32
    localparam logic [10:0] TANK_Y_MAX   = 11'd448;   // 480 - 32
    localparam logic [10:0] BULLET_X_MAX = 11'd636;   // 640 - 4
    localparam logic [10:0] BULLET_Y_MAX = 11'd476;   // 480 - 4
    localparam logic [9:0]  SPAWN_OFFSET = 10'd14;    // centres 4x4 in 32x32

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLIGHT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } bullet_state_t;

    // Maps a keycode onto a facing code; DIR_NONE when it is no direction key.
    function automatic logic [2:0] key_to_dir(input logic [7:0] key);
        logic [2:0] dir;
        dir = DIR_NONE;
        if      (key == KEY_UP)    dir = DIR_UP;
        else if (key == KEY_DOWN)  dir = DIR_DOWN;
        else if (key == KEY_LEFT)  dir = DIR_LEFT;
        else if (key == KEY_RIGHT) dir = DIR_RIGHT;
        return dir;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic          r_frame_q;
    logic [9:0]    r_tank_x;
    logic [9:0]    r_tank_y;
    logic [2:0]    r_tank_dir;
    logic [9:0]    r_bullet_x;
    logic [9:0]    r_bullet_y;
    logic [2:0]    r_bullet_dir;
    logic [5:0]    r_cnt;
    bullet_state_t r_state;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic          w_frame_pulse;
    logic [2:0]    w_dir_a;
    logic [2:0]    w_dir_b;
    logic [2:0]    w_move_dir;
    logic          w_fire_req;
    logic          w_fire_allowed;
    logic          w_fire_go;

    logic [10:0]   w_tank_x_inc;
    logic [10:0]   w_tank_y_inc;
    logic [9:0]    w_tank_x_next;
    logic [9:0]    w_tank_y_next;
    logic [2:0]    w_tank_dir_next;

    logic [10:0]   w_bullet_x_inc;
    logic [10:0]   w_bullet_y_inc;
    logic          w_bullet_out;
    logic [9:0]    w_bullet_x_step;
    logic [9:0]    w_bullet_y_step;

    bullet_state_t w_state_next;
    logic [5:0]    w_cnt_next;
    logic [9:0]    w_bullet_x_next;
    logic [9:0]    w_bullet_y_next;
    logic [2:0]    w_bullet_dir_next;

    // ------------------------------------------------------------------
    // Frame tick edge detect. r_frame_q resets high so a frame_clk that is
    // already high when reset releases does not count as a new frame.
    // ------------------------------------------------------------------
    assign w_frame_pulse = frame_clk & ~r_frame_q;

    // NOTE: every clocked register below uses non-blocking assignments so
    // all of them sample the same pre-edge values regardless of order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_q <= 1'b1;
        end else begin
            r_frame_q <= frame_clk;
        end
    end

    // ------------------------------------------------------------------
    // Keyboard decode: slot A has priority over slot B for movement;
    // fire may come from either slot.
    // ------------------------------------------------------------------
    assign w_dir_a    = key_to_dir(keycode_a);
    assign w_dir_b    = key_to_dir(keycode_b);
    assign w_move_dir = (w_dir_a != DIR_NONE) ? w_dir_a : w_dir_b;
    assign w_fire_req = (keycode_a == KEY_FIRE) || (keycode_b == KEY_FIRE);

    // ------------------------------------------------------------------
    // Tank movement with clamping. Increments are done in 11 bits so the
    // upper clamp compare cannot wrap; decrements are guarded by a compare
    // before subtracting.
    // ------------------------------------------------------------------
    assign w_tank_x_inc = {1'b0, r_tank_x} + {1'b0, TANK_STEP};
    assign w_tank_y_inc = {1'b0, r_tank_y} + {1'b0, TANK_STEP};

    // NOTE: each signal written here gets its default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_tank_x_next   = r_tank_x;
        w_tank_y_next   = r_tank_y;
        w_tank_dir_next = r_tank_dir;
        if (w_move_dir != DIR_NONE) begin
            // Facing follows the key even when the move itself is clamped.
            w_tank_dir_next = w_move_dir;
            case (w_move_dir)
                DIR_UP:
                    w_tank_y_next = (r_tank_y < TANK_STEP) ? 10'd0
                                                           : r_tank_y - TANK_STEP;
                DIR_DOWN:
                    w_tank_y_next = (w_tank_y_inc > TANK_Y_MAX) ? TANK_Y_MAX[9:0]
                                                                : w_tank_y_inc[9:0];
                DIR_LEFT:
                    w_tank_x_next = (r_tank_x < TANK_STEP) ? 10'd0
                                                           : r_tank_x - TANK_STEP;
                DIR_RIGHT:
                    w_tank_x_next = (w_tank_x_inc > TANK_X_MAX) ? TANK_X_MAX[9:0]
                                                                : w_tank_x_inc[9:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bullet step in its latched direction, with a flag for leaving the
    // field. When the flag is set the bullet stays where it is.
    // ------------------------------------------------------------------
    assign w_bullet_x_inc = {1'b0, r_bullet_x} + {1'b0, BULLET_STEP};
    assign w_bullet_y_inc = {1'b0, r_bullet_y} + {1'b0, BULLET_STEP};

    always_comb begin
        w_bullet_out    = 1'b0;
        w_bullet_x_step = r_bullet_x;
        w_bullet_y_step = r_bullet_y;
        case (r_bullet_dir)
            DIR_UP: begin
                w_bullet_out    = (r_bullet_y < BULLET_STEP);
                w_bullet_y_step = r_bullet_y - BULLET_STEP;
            end
            DIR_DOWN: begin
                w_bullet_out    = (w_bullet_y_inc > BULLET_Y_MAX);
                w_bullet_y_step = w_bullet_y_inc[9:0];
            end
            DIR_LEFT: begin
                w_bullet_out    = (r_bullet_x < BULLET_STEP);
                w_bullet_x_step = r_bullet_x - BULLET_STEP;
            end
            DIR_RIGHT: begin
                w_bullet_out    = (w_bullet_x_inc > BULLET_X_MAX);
                w_bullet_x_step = w_bullet_x_inc[9:0];
            end
            // An illegal latched direction would never leave the field, so
            // retire it straight away instead of leaving a stuck bullet.
            default: w_bullet_out = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Fire arming
    // ------------------------------------------------------------------
    assign w_fire_go = (r_state == ST_IDLE) && w_fire_req && w_fire_allowed;

`ifdef TANK_AUTOFIRE_EN
    // Held fire re-fires as soon as the FSM is back in IDLE.
    assign w_fire_allowed = 1'b1;
`else
    logic r_fire_armed;

    // Armed by any frame without a fire request, disarmed by a shot, so a
    // held key yields exactly one shot.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fire_armed <= 1'b1;
        end else if (w_frame_pulse) begin
            if (w_fire_go) begin
                r_fire_armed <= 1'b0;
            end else if (!w_fire_req) begin
                r_fire_armed <= 1'b1;
            end
        end
    end

    assign w_fire_allowed = r_fire_armed;
`endif

    // ------------------------------------------------------------------
    // Bullet FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_bullet_x_next   = r_bullet_x;
        w_bullet_y_next   = r_bullet_y;
        w_bullet_dir_next = r_bullet_dir;
        case (r_state)
            ST_IDLE: begin
                if (w_fire_go) begin
                    // Spawn from the tank's position and facing before this
                    // frame's movement is applied.
                    w_state_next      = ST_FLIGHT;
                    w_bullet_x_next   = r_tank_x + SPAWN_OFFSET;
                    w_bullet_y_next   = r_tank_y + SPAWN_OFFSET;
                    w_bullet_dir_next = r_tank_dir;
                end
            end
            ST_FLIGHT: begin
                if (w_bullet_out) begin
                    w_state_next = ST_COOLDOWN;
                    w_cnt_next   = COOLDOWN_FRAMES - 6'd1;
                end else begin
                    w_bullet_x_next = w_bullet_x_step;
                    w_bullet_y_next = w_bullet_y_step;
                end
            end
            ST_COOLDOWN: begin
                // cnt counts down to 0 and the frame that sees 0 returns to
                // IDLE, giving COOLDOWN_FRAMES frames in this state.
                if (r_cnt == 6'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 6'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else if (w_frame_pulse) begin
            r_state <= w_state_next;
        end
    end

    // Per-frame datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tank_x     <= START_X;
            r_tank_y     <= START_Y;
            r_tank_dir   <= START_DIR;
            r_bullet_x   <= 10'd0;
            r_bullet_y   <= 10'd0;
            r_bullet_dir <= START_DIR;
            r_cnt        <= 6'd0;
        end else if (w_frame_pulse) begin
            r_tank_x     <= w_tank_x_next;
            r_tank_y     <= w_tank_y_next;
            r_tank_dir   <= w_tank_dir_next;
            r_bullet_x   <= w_bullet_x_next;
            r_bullet_y   <= w_bullet_y_next;
            r_bullet_dir <= w_bullet_dir_next;
            r_cnt        <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs and pixel hit tests (zero latency from DrawX/DrawY)
    // ------------------------------------------------------------------
    logic [10:0] w_draw_x;
    logic [10:0] w_draw_y;
    logic [10:0] w_tank_x_ext;
    logic [10:0] w_tank_y_ext;
    logic [10:0] w_bullet_x_ext;
    logic [10:0] w_bullet_y_ext;

    assign w_draw_x       = {1'b0, DrawX};
    assign w_draw_y       = {1'b0, DrawY};
    assign w_tank_x_ext   = {1'b0, r_tank_x};
    assign w_tank_y_ext   = {1'b0, r_tank_y};
    assign w_bullet_x_ext = {1'b0, r_bullet_x};
    assign w_bullet_y_ext = {1'b0, r_bullet_y};

    assign is_tank = (w_draw_x >= w_tank_x_ext) && (w_draw_x < w_tank_x_ext + TANK_SIZE) &&
                     (w_draw_y >= w_tank_y_ext) && (w_draw_y < w_tank_y_ext + TANK_SIZE);

    assign is_shooting = (r_state == ST_FLIGHT);

    assign is_bullet = is_shooting &&
                       (w_draw_x >= w_bullet_x_ext) && (w_draw_x < w_bullet_x_ext + BULLET_SIZE) &&
                       (w_draw_y >= w_bullet_y_ext) && (w_draw_y < w_bullet_y_ext + BULLET_SIZE);

    assign tankX    = r_tank_x;
    assign tankY    = r_tank_y;
    assign tank_dir = r_tank_dir;
    assign bulletX  = r_bullet_x;
    assign bulletY  = r_bullet_y;

endmodule

// File: tb/tb_tank_controller.sv
// ============================================================================
// tb_tank_controller
// ----------------------------------------------------------------------------
// Directed testbench for tank_controller with default parameters. A single
// linear stimulus sequence drives keycodes and frame ticks; every expected
// value is hand-computed from the tank/bullet movement rules.
// ============================================================================
`timescale 1ns/1ps

module tb_tank_controller;

    localparam logic [7:0] K_NONE  = 8'h00;
    localparam logic [7:0] K_UP    = 8'h1A;
    localparam logic [7:0] K_DOWN  = 8'h16;
    localparam logic [7:0] K_LEFT  = 8'h04;
    localparam logic [7:0] K_RIGHT = 8'h07;
    localparam logic [7:0] K_FIRE  = 8'h2C;
    localparam logic [7:0] K_OTHER = 8'h55;

`ifdef TANK_AUTOFIRE_EN
    localparam logic AUTOFIRE = 1'b1;
`else
    localparam logic AUTOFIRE = 1'b0;
`endif

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode_a;
    logic [7:0] keycode_b;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] tankX;
    logic [9:0] tankY;
    logic [2:0] tank_dir;
    logic       is_tank;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic       is_shooting;
    logic       is_bullet;

    int tests_run;
    int tests_failed;

    tank_controller dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .keycode_a   (keycode_a),
        .keycode_b   (keycode_b),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .tankX       (tankX),
        .tankY       (tankY),
        .tank_dir    (tank_dir),
        .is_tank     (is_tank),
        .bulletX     (bulletX),
        .bulletY     (bulletY),
        .is_shooting (is_shooting),
        .is_bullet   (is_bullet)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One frame: keys held while frame_clk is high for two Clk cycles, then
    // low for one. Returns on a falling Clk edge, away from the update edge.
    task automatic do_frame(input logic [7:0] ka, input logic [7:0] kb);
        @(negedge Clk);
        keycode_a = ka;
        keycode_b = kb;
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        keycode_a = K_NONE;
        keycode_b = K_NONE;
    endtask

    task automatic do_frames(input int n, input logic [7:0] ka, input logic [7:0] kb);
        for (int i = 0; i < n; i++) do_frame(ka, kb);
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset_n      = 1'b0;
        frame_clk    = 1'b0;
        keycode_a    = K_NONE;
        keycode_b    = K_NONE;
        DrawX        = 10'd0;
        DrawY        = 10'd0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge Clk);
        check("rst_tankX", tankX, 32);
        check("rst_tankY", tankY, 224);
        check("rst_dir", tank_dir, 3'b010);
        check("rst_shooting", is_shooting, 0);
        check("rst_bulletX", bulletX, 0);
        check("rst_bulletY", bulletY, 0);
        probe(10'd40, 10'd230);
        check("rst_is_tank_in", is_tank, 1);
        check("rst_is_bullet", is_bullet, 0);
        probe(10'd31, 10'd230);
        check("rst_is_tank_left_edge", is_tank, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // ---------------- movement and key priority ----------------
        do_frame(K_RIGHT, K_NONE);
        check("right_tankX", tankX, 34);
        check("right_dir", tank_dir, 3'b010);
        do_frame(K_NONE, K_LEFT);
        check("slotb_left_tankX", tankX, 32);
        check("slotb_left_dir", tank_dir, 3'b011);
        do_frame(K_LEFT, K_RIGHT);
        check("a_wins_tankX", tankX, 30);
        check("a_wins_dir", tank_dir, 3'b011);
        do_frame(K_OTHER, K_RIGHT);
        check("a_nomatch_tankX", tankX, 32);
        check("a_nomatch_dir", tank_dir, 3'b010);

        // Long frame_clk high: only one update.
        @(negedge Clk);
        keycode_a = K_RIGHT;
        frame_clk = 1'b1;
        repeat (10) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        keycode_a = K_NONE;
        check("long_frame_tankX", tankX, 34);

        // ---------------- up clamp ----------------
        do_frames(111, K_UP, K_NONE);
        check("up_tankY_2", tankY, 2);
        check("up_dir", tank_dir, 3'b001);
        do_frame(K_UP, K_NONE);
        check("up_tankY_0", tankY, 0);
        do_frame(K_UP, K_NONE);
        check("up_clamped_tankY", tankY, 0);
        check("up_clamped_dir", tank_dir, 3'b001);

        // ---------------- move to (100,100) facing right ----------------
        do_frames(32, K_RIGHT, K_NONE);
        do_frames(50, K_DOWN, K_NONE);
        check("down_dir", tank_dir, 3'b100);
        do_frame(K_RIGHT, K_NONE);
        check("pos_tankX", tankX, 100);
        check("pos_tankY", tankY, 100);
        check("pos_dir", tank_dir, 3'b010);
        probe(10'd131, 10'd131);
        check("is_tank_corner", is_tank, 1);
        probe(10'd132, 10'd131);
        check("is_tank_right_edge", is_tank, 0);
        probe(10'd100, 10'd99);
        check("is_tank_top_edge", is_tank, 0);

        // ---------------- first shot, flight to right edge ----------------
        do_frame(K_FIRE, K_NONE);
        check("shot1_bulletX", bulletX, 114);
        check("shot1_bulletY", bulletY, 114);
        check("shot1_shooting", is_shooting, 1);
        check("shot1_tankX", tankX, 100);
        probe(10'd117, 10'd117);
        check("is_bullet_in", is_bullet, 1);
        probe(10'd118, 10'd117);
        check("is_bullet_right_edge", is_bullet, 0);
        probe(10'd114, 10'd113);
        check("is_bullet_top_edge", is_bullet, 0);

        do_frames(87, K_NONE, K_NONE);
        check("edge_bulletX", bulletX, 636);
        check("edge_bulletY", bulletY, 114);
        check("edge_shooting", is_shooting, 1);
        do_frame(K_NONE, K_NONE);
        check("end_shooting", is_shooting, 0);
        check("end_bulletX_held", bulletX, 636);
        probe(10'd636, 10'd114);
        check("is_bullet_cooldown", is_bullet, 0);

        // ---------------- cooldown length ----------------
        do_frame(K_FIRE, K_NONE);                  // cooldown frame 1
        check("cool_fire_ignored", is_shooting, 0);
        do_frames(28, K_NONE, K_NONE);             // frames 2..29
        do_frame(K_FIRE, K_NONE);                  // frame 30: returns to IDLE
        check("cool_last_frame", is_shooting, 0);
        do_frame(K_FIRE, K_NONE);                  // first IDLE frame
        check("shot2_shooting", is_shooting, 1);
        check("shot2_bulletX", bulletX, 114);

        // ---------------- fire held through flight and cooldown ----------
        do_frame(K_FIRE, K_NONE);
        check("held_flight_bulletX", bulletX, 120);
        do_frames(86, K_FIRE, K_NONE);
        check("held_edge_bulletX", bulletX, 636);
        do_frame(K_FIRE, K_NONE);
        check("held_end_shooting", is_shooting, 0);
        do_frames(30, K_FIRE, K_NONE);
        check("held_idle_shooting", is_shooting, 0);
        do_frame(K_FIRE, K_NONE);
        check("held_first_idle_frame", is_shooting, AUTOFIRE);
        do_frame(K_FIRE, K_NONE);
        check("held_second_idle_frame", is_shooting, AUTOFIRE);
        do_frame(K_NONE, K_NONE);
        do_frame(K_FIRE, K_NONE);
        check("rearmed_shooting", is_shooting, 1);

        // ---------------- async reset mid-flight ----------------
        do_frame(K_NONE, K_NONE);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        check("async_rst_shooting", is_shooting, 0);
        check("async_rst_tankX", tankX, 32);
        check("async_rst_tankY", tankY, 224);
        check("async_rst_dir", tank_dir, 3'b010);
        check("async_rst_bulletX", bulletX, 0);
        #1 Reset_n = 1'b1;
        do_frame(K_NONE, K_NONE);
        check("post_rst_no_bullet", is_shooting, 0);

        // Reset released while frame_clk is already high: no update.
        @(negedge Clk);
        keycode_a = K_RIGHT;
        frame_clk = 1'b1;
        #1 Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("no_spurious_pulse_tankX", tankX, 32);
        frame_clk = 1'b0;
        keycode_a = K_NONE;
        @(negedge Clk);

        // ---------------- same-frame spawn uses pre-update tank ----------
        do_frame(K_LEFT, K_NONE);
        check("pre_tankX", tankX, 30);
        check("pre_dir", tank_dir, 3'b011);
        do_frame(K_FIRE, K_RIGHT);
        check("spawn_bulletX", bulletX, 44);
        check("spawn_bulletY", bulletY, 238);
        check("spawn_shooting", is_shooting, 1);
        check("spawn_tankX_moved", tankX, 32);
        check("spawn_tank_dir", tank_dir, 3'b010);
        do_frame(K_NONE, K_NONE);
        check("left_flight_bulletX", bulletX, 38);
        check("left_flight_bulletY", bulletY, 238);
        do_frames(6, K_NONE, K_NONE);
        check("left_edge_bulletX", bulletX, 2);
        check("left_edge_shooting", is_shooting, 1);
        do_frame(K_NONE, K_NONE);
        check("left_end_shooting", is_shooting, 0);
        check("left_end_bulletX", bulletX, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
